pipe_hazard_ctrl: RTL and testbench

Central stall/flush controller for the five-stage pipeline. It drives the per-register stall inputs of the PC, IF/ID, ID/EX and EX/MEM pipeline registers, and the bubble/flush controls beside them. It resolves four hazard sources: data-memory wait, multi-cycle multiply/divide (MDU) occupancy, load-use dependency and taken-branch squash. It sits beside the datapath and owns no data; it only decides which registers hold, advance or clear each cycle.

---
 rtl/pipe_ctrl_pkg.sv | 17 +
 rtl/pipe_hazard_ctrl_mdu_seq.sv | 69 ++++++
 rtl/pipe_hazard_ctrl.sv | 93 +++++++++
 tb/tb_pipe_hazard_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Holds the MDU sequencer state encoding and the default widths/latencies.
package pipe_ctrl_pkg;

    localparam int RA_W_DEF    = 5;
    localparam int MDU_LAT_DEF = 4;
    localparam int MDU_LAT_MAX = 16;
    localparam int CNT_W       = 4;
    localparam int REG_ZERO    = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_mdu_seq.sv
// MDU occupancy sequencer: launches the unit, counts its latency and flags completion.
// Only instantiated when PIPE_MDU_EN is defined.
module mdu_seq
    import pipe_ctrl_pkg::*;
#(
    parameter int MDU_LAT = MDU_LAT_DEF
) (
    input  logic clk,
    input  logic clr,
    input  logic ex_mdu_op,
    input  logic mem_wait,
    output logic mdu_stall,
    output logic mdu_start,
    output logic mdu_done
);

    // Launch cycle counts as the first stall cycle, so BUSY lasts MDU_LAT-1 cycles.
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MDU_LAT - 2);

    mdu_state_t       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        mdu_stall = 1'b0;
        mdu_start = 1'b0;
        mdu_done  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ex_mdu_op) begin
                    mdu_stall = 1'b1;
                    if (!mem_wait) begin
                        mdu_start = 1'b1;
                        cnt_n     = CNT_INIT;
                        state_n   = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                mdu_stall = 1'b1;
                if (cnt == '0) begin
                    state_n = ST_DONE;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            ST_DONE: begin
                // The finished instruction is still in EX; hold until MEM accepts it.
                mdu_done = 1'b1;
                if (!mem_wait) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: prioritises mem_wait, MDU, load-use and branch flush.
// Optional MDU sequencing is enabled by defining PIPE_MDU_EN.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MDU_LAT = MDU_LAT_DEF,
    parameter int RA_W    = RA_W_DEF
) (
    input  logic            clk,
    input  logic            clr,
    input  logic [RA_W-1:0] id_rs,
    input  logic [RA_W-1:0] id_rt,
    input  logic            id_uses_rs,
    input  logic            id_uses_rt,
    input  logic            id_branch_taken,
    input  logic [RA_W-1:0] ex_rd,
    input  logic            ex_load,
    input  logic            ex_mdu_op,
    input  logic            mem_wait,
    output logic            pc_stall,
    output logic            ifid_stall,
    output logic            idex_stall,
    output logic            exmem_stall,
    output logic            ifid_flush,
    output logic            idex_bubble,
    output logic            exmem_bubble,
    output logic            mdu_start,
    output logic            mdu_done
);

    localparam logic [RA_W-1:0] RZ = RA_W'(REG_ZERO);

    logic mdu_stall, mdu_start_raw, mdu_done_raw;
    logic load_use;

`ifdef PIPE_MDU_EN
    mdu_seq #(
        .MDU_LAT (MDU_LAT)
    ) u_mdu_seq (
        .clk       (clk),
        .clr       (clr),
        .ex_mdu_op (ex_mdu_op),
        .mem_wait  (mem_wait),
        .mdu_stall (mdu_stall),
        .mdu_start (mdu_start_raw),
        .mdu_done  (mdu_done_raw)
    );
`else
    logic unused_mdu;
    assign unused_mdu    = ^{ex_mdu_op, clk};
    assign mdu_stall     = 1'b0;
    assign mdu_start_raw = 1'b0;
    assign mdu_done_raw  = 1'b0;
`endif

    assign load_use = ex_load && (ex_rd != RZ) &&
                      ((id_uses_rs && (id_rs == ex_rd)) ||
                       (id_uses_rt && (id_rt == ex_rd)));

    always_comb begin
        pc_stall     = 1'b0;
        ifid_stall   = 1'b0;
        idex_stall   = 1'b0;
        exmem_stall  = 1'b0;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        mdu_start    = 1'b0;
        mdu_done     = 1'b0;
        if (!clr) begin
            if (mem_wait) begin
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_stall  = 1'b1;
                exmem_stall = 1'b1;
            end else if (mdu_stall) begin
                pc_stall     = 1'b1;
                ifid_stall   = 1'b1;
                idex_stall   = 1'b1;
                exmem_bubble = 1'b1;
            end else if (load_use) begin
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_bubble = 1'b1;
            end
            // A branch held in ID re-resolves next cycle rather than being flushed now.
            ifid_flush = id_branch_taken && !ifid_stall;
            mdu_start  = mdu_start_raw;
            mdu_done   = mdu_done_raw;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios then randomized traffic
// against a cycle-level reference model of the stall/flush rules.
module tb_pipe_hazard_ctrl;

    localparam int LAT = 4;
    localparam int RAW = 5;

    logic           clk = 1'b0;
    logic           clr;
    logic [RAW-1:0] id_rs, id_rt, ex_rd;
    logic           id_uses_rs, id_uses_rt, id_branch_taken;
    logic           ex_load, ex_mdu_op, mem_wait;
    logic           pc_stall, ifid_stall, idex_stall, exmem_stall;
    logic           ifid_flush, idex_bubble, exmem_bubble, mdu_start, mdu_done;

    pipe_hazard_ctrl #(.MDU_LAT(LAT), .RA_W(RAW)) dut (
        .clk             (clk),
        .clr             (clr),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .id_branch_taken (id_branch_taken),
        .ex_rd           (ex_rd),
        .ex_load         (ex_load),
        .ex_mdu_op       (ex_mdu_op),
        .mem_wait        (mem_wait),
        .pc_stall        (pc_stall),
        .ifid_stall      (ifid_stall),
        .idex_stall      (idex_stall),
        .exmem_stall     (exmem_stall),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .exmem_bubble    (exmem_bubble),
        .mdu_start       (mdu_start),
        .mdu_done        (mdu_done)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: cycles of MDU occupancy still to come after launch, and a result-ready flag.
    int m_left = 0;
    bit m_done = 1'b0;
    bit e_pc, e_ifid, e_idex, e_exmem, e_flush, e_idb, e_exb, e_start, e_done;

    task automatic chk(input string tag, input logic obs, input logic req);
        n_assert++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, req);
        end
    endtask

    task automatic model_eval();
        bit lu, ms, mst, md;
        {e_pc, e_ifid, e_idex, e_exmem, e_flush, e_idb, e_exb, e_start, e_done} = '0;
        lu = 0; ms = 0; mst = 0; md = 0;
        if (!clr) begin
            lu = ex_load && (ex_rd != 0) &&
                 ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
`ifdef PIPE_MDU_EN
            if (m_done) md = 1;
            else if (m_left > 0) ms = 1;
            else if (ex_mdu_op) begin ms = 1; mst = !mem_wait; end
`endif
            if (mem_wait) {e_pc, e_ifid, e_idex, e_exmem} = 4'b1111;
            else if (ms) begin {e_pc, e_ifid, e_idex} = 3'b111; e_exb = 1; end
            else if (lu) begin {e_pc, e_ifid} = 2'b11; e_idb = 1; end
            e_flush = id_branch_taken && !e_ifid;
            e_start = mst;
            e_done  = md;
        end
    endtask

    task automatic model_update();
        if (clr) begin
            m_left = 0;
            m_done = 0;
        end else begin
`ifdef PIPE_MDU_EN
            if (m_done) begin
                if (!mem_wait) m_done = 0;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_done = 1;
            end else if (ex_mdu_op && !mem_wait) begin
                m_left = LAT - 1;
            end
`endif
        end
    endtask

    task automatic sample();
        @(negedge clk);
        model_eval();
        chk("pc_stall",     pc_stall,     e_pc);
        chk("ifid_stall",   ifid_stall,   e_ifid);
        chk("idex_stall",   idex_stall,   e_idex);
        chk("exmem_stall",  exmem_stall,  e_exmem);
        chk("ifid_flush",   ifid_flush,   e_flush);
        chk("idex_bubble",  idex_bubble,  e_idb);
        chk("exmem_bubble", exmem_bubble, e_exb);
        chk("mdu_start",    mdu_start,    e_start);
        chk("mdu_done",     mdu_done,     e_done);
    endtask

    task automatic adv();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        clr = 0; id_rs = 0; id_rt = 0; ex_rd = 0;
        id_uses_rs = 0; id_uses_rt = 0; id_branch_taken = 0;
        ex_load = 0; ex_mdu_op = 0; mem_wait = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        // Reset, with hazards present to prove outputs are forced low
        clr = 1; ex_mdu_op = 1; mem_wait = 1; id_branch_taken = 1;
        sample();
        chk("rst_pc", pc_stall, 1'b0);
        chk("rst_exmem", exmem_stall, 1'b0);
        chk("rst_flush", ifid_flush, 1'b0);
        adv();
        idle_inputs();
        sample();
        adv();

        // Load-use on rs
        ex_load = 1; ex_rd = 5; id_rs = 5; id_uses_rs = 1;
        sample();
        chk("lu_pc", pc_stall, 1'b1);
        chk("lu_ifid", ifid_stall, 1'b1);
        chk("lu_bubble", idex_bubble, 1'b1);
        chk("lu_idex", idex_stall, 1'b0);
        adv();
        ex_load = 0;
        sample();
        chk("lu_clear_pc", pc_stall, 1'b0);
        chk("lu_clear_bubble", idex_bubble, 1'b0);
        adv();

        // Register zero and unused source never stall
        ex_load = 1; ex_rd = 0; id_rs = 0; id_uses_rs = 1;
        sample();
        chk("r0_pc", pc_stall, 1'b0);
        adv();
        id_uses_rs = 0; id_rs = 7; ex_rd = 7;
        sample();
        chk("nouse_pc", pc_stall, 1'b0);
        adv();

        // Load-use on rt with a taken branch: flush suppressed, then applied
        idle_inputs();
        ex_load = 1; ex_rd = 3; id_rt = 3; id_uses_rt = 1; id_branch_taken = 1;
        sample();
        chk("lu_br_flush", ifid_flush, 1'b0);
        adv();
        ex_load = 0;
        sample();
        chk("br_flush", ifid_flush, 1'b1);
        adv();

        // MDU launch and completion
        idle_inputs();
        ex_mdu_op = 1;
        for (int c = 0; c < 6; c++) begin
            if (c == 5) ex_mdu_op = 0;
            sample();
`ifdef PIPE_MDU_EN
            chk("mdu_start_c", mdu_start, (c == 0) ? 1'b1 : 1'b0);
            chk("mdu_pc_c", pc_stall, (c < 4) ? 1'b1 : 1'b0);
            chk("mdu_exb_c", exmem_bubble, (c < 4) ? 1'b1 : 1'b0);
            chk("mdu_done_c", mdu_done, (c == 4) ? 1'b1 : 1'b0);
`else
            chk("nomdu_pc", pc_stall, 1'b0);
            chk("nomdu_start", mdu_start, 1'b0);
`endif
            adv();
        end

        // mem_wait stretches DONE
        ex_mdu_op = 1;
        for (int c = 0; c < 8; c++) begin
            mem_wait = (c == 4 || c == 5);
            if (c == 7) ex_mdu_op = 0;
            sample();
`ifdef PIPE_MDU_EN
            if (c >= 4 && c <= 6) chk("mw_done", mdu_done, 1'b1);
            if (c == 4 || c == 5) chk("mw_exmem", exmem_stall, 1'b1);
            if (c == 7) chk("mw_idle", mdu_done, 1'b0);
`endif
            adv();
        end

        // Reset mid-BUSY aborts without mdu_done
        idle_inputs();
        ex_mdu_op = 1;
        sample(); adv();
        sample(); adv();
        clr = 1;
        sample();
        chk("clr_busy_pc", pc_stall, 1'b0);
        chk("clr_busy_done", mdu_done, 1'b0);
        adv();
        clr = 0; ex_mdu_op = 0;
        for (int c = 0; c < 5; c++) begin
            sample();
            chk("post_clr_done", mdu_done, 1'b0);
            adv();
        end

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            clr             = ($urandom_range(0, 99) == 0);
            id_rs           = RAW'($urandom_range(0, 7));
            id_rt           = RAW'($urandom_range(0, 7));
            ex_rd           = RAW'($urandom_range(0, 7));
            id_uses_rs      = $urandom_range(0, 1);
            id_uses_rt      = $urandom_range(0, 1);
            id_branch_taken = ($urandom_range(0, 3) == 0);
            ex_load         = ($urandom_range(0, 2) == 0);
            ex_mdu_op       = ($urandom_range(0, 9) == 0);
            mem_wait        = ($urandom_range(0, 4) == 0);
            sample();
            adv();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
